rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have issue_valid  input  1, issue_rd  input  ADDR_W, issue_ready  output  1: reserves a destination register.
REQ-006 SHALL have req0_valid  input  1, req0_rd  input  ADDR_W, req0_data  input  DATA_W, req0_ready  output  1: ALU writeback requester.
REQ-007 SHALL have req1_valid  input  1, req1_rd  input  ADDR_W, req1_data  input  DATA_W, req1_ready  output  1: load writeback requester.
REQ-008 SHALL have RegWrite  output  1, WriteRegister  output  ADDR_W, WriteData  output  DATA_W: register-file write port.
REQ-009 SHALL have rs1  input  ADDR_W, rs2  input  ADDR_W, stall  output  1: read-hazard query.

Function
REQ-010 SHALL hold a 32-bit busy scoreboard; busy[0] is constant 0.
REQ-011 SHALL drive issue_ready = (issue_rd==0) | !busy[issue_rd]. A transfer is issue_valid & issue_ready.
REQ-012 SHALL set busy[issue_rd] on the edge that completes an issue transfer with issue_rd!=0.
REQ-013 SHALL grant at most one of req0/req1 per cycle. readyN is high only for the granted requester.
REQ-014 SHALL grant req1 over req0 when both are valid, unless RR_ARB_EN is defined (REQ-026).
REQ-015 SHALL register the granted rd/data into the output stage, so RegWrite pulses exactly one cycle after the handshake edge (latency 1).
REQ-016 SHALL drive RegWrite=0 for an accepted request with rd==0. Such a request is still consumed (ready=1).
REQ-017 SHALL clear busy[WriteRegister] on the edge at the end of the cycle in which RegWrite=1.
  - Busy stays set while the write is in flight.
  - A reader never sees stall low before the register file holds the new value.
REQ-018 SHALL let the set win when an issue to rd X and a clear of X coincide on the same edge. X then remains busy.
REQ-019 SHALL drive stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]), combinationally.
REQ-020 SHALL accept a writeback to a register whose busy bit is clear. The write still occurs and busy remains clear.
REQ-021 SHALL hold RegWrite=0 with WriteRegister/WriteData unchanged in cycles with no grant.
REQ-022 SHALL keep the arbiter state and scoreboard unchanged when no request is valid.

Reset
REQ-023 SHALL, while rst=1, clear the busy scoreboard, RegWrite, WriteRegister and WriteData to 0, and set the RR pointer to favour req0.
REQ-024 SHALL drop a handshake whose edge coincides with rst=1. No write is produced after reset is released.
REQ-025 SHALL drive issue_ready=1, req0_ready=0, req1_ready=0 and stall=0 during reset and in the first cycle after it.

Configuration
REQ-026 SHALL, with RF_WB_RR_ARB_EN defined, use round-robin arbitration: on contention, grant the requester not granted last.
  - A 1-bit last-grant pointer updates on each grant.
REQ-027 SHALL, without RF_WB_RR_ARB_EN, use fixed priority (req1 > req0) and contain no pointer flop.

Structure
REQ-028 SHALL place DATA_W/ADDR_W defaults, the zero-register constant and the requester-id enum (REQ_ALU=0, REQ_LOAD=1) in the shared package rf_wb_pkg.
REQ-029 SHALL implement the grant logic as sub-module rf_wb_grant (2-input arbiter including the optional pointer). Scoreboard and output stage are in the top module.

Verification
REQ-030 SHALL check: issue rd=5, then query rs1=5 -> stall=1. req0 rd=5 data=0xDEADBEEF -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, stall=1. One cycle later stall=0.
REQ-031 SHALL check: req0 and req1 valid together for 4 cycles, rd 3/4. Fixed priority -> req1 granted all 4 cycles. RR build -> grants alternate 1,0,1,0.
REQ-032 SHALL check: issue rd=7 on the same edge as RegWrite to rd=7 -> busy[7] remains 1 and stall on rs2=7 stays 1.
REQ-033 SHALL check: req1 rd=0 data=0x1234 -> req1_ready=1, RegWrite stays 0. Issue rd=0 -> issue_ready=1, stall on rs1=0 stays 0.
REQ-034 SHALL check: busy[9] set, issue rd=9 -> issue_ready=0 until the write to 9 retires.
REQ-035 SHALL check: assert rst on a handshake edge with rd=2 pending -> busy cleared, no RegWrite pulse after release.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Optional feature macro: RF_WB_RR_ARB_EN (round-robin arbitration).
package rf_wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // x0 is hardwired; writes to it are swallowed and it is never busy
    localparam int ZERO_REG = 0;

    // Writeback requester identity
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } reqId_e;

endpackage

// File: rtl/rf_wb_grant.sv
// Two-input writeback arbiter.
// RF_WB_RR_ARB_EN defined   : round-robin on contention via a 1-bit last-grant pointer.
// RF_WB_RR_ARB_EN undefined : fixed priority, load (req1) over ALU (req0), no state.
module rf_wb_grant
    import rf_wb_pkg::*;
(
`ifdef RF_WB_RR_ARB_EN
    input  logic   clk,
    input  logic   rst,
`endif
    input  logic   valid0,
    input  logic   valid1,
    output logic   grant0,
    output logic   grant1,
    output reqId_e grantId
);

`ifdef RF_WB_RR_ARB_EN
    reqId_e lastGrant;
    logic   prefer0;

    // Requester 0 wins a tie only if requester 1 took the previous grant
    assign prefer0 = (lastGrant == REQ_LOAD);

    // Grant decode: uncontested requests always win, ties go to the non-last winner
    always_comb begin
        grant0 = valid0 & (!valid1 | prefer0);
        grant1 = valid1 & (!valid0 | !prefer0);
    end

    // Pointer tracks the most recent grant; reset leaves req0 favoured
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lastGrant <= REQ_LOAD;
        else if (grant0 | grant1)
            lastGrant <= grant1 ? REQ_LOAD : REQ_ALU;
    end
`else
    // Fixed priority: loads retire first
    always_comb begin
        grant1 = valid1;
        grant0 = valid0 & !valid1;
    end
`endif

    assign grantId = grant1 ? REQ_LOAD : REQ_ALU;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a busy scoreboard.
// Issue reserves a destination, one of two writeback requesters is granted per
// cycle and registered into the write port, and the write clears the busy bit
// on the edge that ends the write cycle, so stall drops only once the RF holds
// the new value.
// Optional feature macro: RF_WB_RR_ARB_EN (round-robin instead of fixed priority).
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              stall
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RZERO = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;
    logic              rstHold;
    logic              v0;
    logic              v1;
    logic              gnt0;
    logic              gnt1;
    reqId_e            gntId;
    logic              issueFire;
    logic              wbFire;
    logic [ADDR_W-1:0] wbRd;
    logic [DATA_W-1:0] wbData;

    // Requesters are masked for the first cycle after reset so no handshake
    // can be taken before the machine is settled
    assign v0 = req0_valid & !rstHold;
    assign v1 = req1_valid & !rstHold;

    rf_wb_grant uGrant (
`ifdef RF_WB_RR_ARB_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .valid0  (v0),
        .valid1  (v1),
        .grant0  (gnt0),
        .grant1  (gnt1),
        .grantId (gntId)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign wbFire     = gnt0 | gnt1;
    assign wbRd       = (gntId == REQ_LOAD) ? req1_rd   : req0_rd;
    assign wbData     = (gntId == REQ_LOAD) ? req1_data : req0_data;

    assign issue_ready = (issue_rd == RZERO) | !busy[issue_rd];
    assign issueFire   = issue_valid & issue_ready;

    assign stall = ((rs1 != RZERO) & busy[rs1]) | ((rs2 != RZERO) & busy[rs2]);

    // One-cycle post-reset hold: high during reset, drops on the first clean edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rstHold <= 1'b1;
        else
            rstHold <= 1'b0;
    end

    // Output stage: latency 1, x0 writes consumed but never asserted, hold on idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (wbFire) begin
            RegWrite      <= (wbRd != RZERO);
            WriteRegister <= wbRd;
            WriteData     <= wbData;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // Scoreboard next state: retire clears, then issue sets so a same-edge issue wins
    always_comb begin
        busyNext = busy;
        if (RegWrite)
            busyNext[WriteRegister] = 1'b0;
        if (issueFire)
            busyNext[issue_rd] = 1'b1;
        busyNext[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busyNext;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
// Build with +define+RF_WB_RR_ARB_EN to check the round-robin variant.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic          req0_valid;
    logic [AW-1:0] req0_rd;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_rd;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          stall;

    int checks = 0;
    int fails  = 0;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .req0_valid    (req0_valid),
        .req0_rd       (req0_rd),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_rd       (req1_rd),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .rs1           (rs1),
        .rs2           (rs2),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2;
        rs1 = 5'd1; rs2 = 5'd2;
        step(); step();
        checks++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: got RegWrite=%b WR=%0d WD=%h, want 0/0/0", RegWrite, WriteRegister, WriteData);
        end
        checks++;
        if (issue_ready !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: got ir=%b r0=%b r1=%b st=%b, want 1/0/0/0", issue_ready, req0_ready, req1_ready, stall);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || issue_ready !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_cycle: got ir=%b r0=%b r1=%b st=%b, want 1/0/0/0", issue_ready, req0_ready, req1_ready, stall);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_nowrite: got RegWrite=%b, want 0", RegWrite);
        end
    endtask

    task automatic test_basic_writeback();
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue5_ready: got %b, want 1", issue_ready);
        end
        step();
        issue_valid = 1'b0;
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL stall_after_issue5: got %b, want 1", stall);
        end
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL req0_ready_single: got r0=%b r1=%b, want 1/0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF || stall !== 1'b1) begin
            fails++;
            $display("FAIL wb5_port: got RW=%b WR=%0d WD=%h st=%b, want 1/5/deadbeef/1", RegWrite, WriteRegister, WriteData, stall);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0 || stall !== 1'b0 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wb5_retire: got RW=%b st=%b WR=%0d WD=%h, want 0/0/5/deadbeef", RegWrite, stall, WriteRegister, WriteData);
        end
    endtask

    task automatic test_contention();
        logic [3:0] expLoad;
`ifdef RF_WB_RR_ARB_EN
        expLoad = 4'b0101;  // cycle0 load, cycle1 alu, ... (last grant was alu)
`else
        expLoad = 4'b1111;
`endif
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hAAAA0003;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'hBBBB0004;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req1_ready !== expLoad[i] || req0_ready !== !expLoad[i]) begin
                fails++;
                $display("FAIL contend_grant%0d: got r0=%b r1=%b, want r1=%b", i, req0_ready, req1_ready, expLoad[i]);
            end
            step();
            checks++;
            if (RegWrite !== 1'b1 || WriteRegister !== (expLoad[i] ? 5'd4 : 5'd3) ||
                WriteData !== (expLoad[i] ? 32'hBBBB0004 : 32'hAAAA0003)) begin
                fails++;
                $display("FAIL contend_write%0d: got RW=%b WR=%0d WD=%h, want load=%b", i, RegWrite, WriteRegister, WriteData, expLoad[i]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        checks++;
        if (RegWrite !== 1'b0 || WriteRegister !== (expLoad[3] ? 5'd4 : 5'd3)) begin
            fails++;
            $display("FAIL idle_hold: got RW=%b WR=%0d, want 0 and held", RegWrite, WriteRegister);
        end
    endtask

    task automatic test_set_wins();
        // Write to a non-busy register, then issue it on the retire edge
        rs1 = 5'd0; rs2 = 5'd7;
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
        step();
        req0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || issue_ready !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL setwin_pre: got RW=%b WR=%0d ir=%b st=%b, want 1/7/1/0", RegWrite, WriteRegister, issue_ready, stall);
        end
        step();
        issue_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL setwin_busy7: got stall=%b, want 1", stall);
        end
        step();
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL setwin_hold7: got stall=%b, want 1", stall);
        end
        // Retire 7 properly
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h78;
        step();
        req0_valid = 1'b0;
        step();
        checks++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL setwin_clear7: got stall=%b, want 0", stall);
        end
    endtask

    task automatic test_zero_reg();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_req1_ready: got %b, want 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL x0_nowrite: got RegWrite=%b, want 0", RegWrite);
        end
        issue_valid = 1'b1; issue_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_issue_ready: got %b, want 1", issue_ready);
        end
        step();
        issue_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL x0_stall: got stall=%b RW=%b, want 0/0", stall, RegWrite);
        end
    endtask

    task automatic test_issue_block();
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy9_block: got issue_ready=%b, want 0", issue_ready);
        end
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || RegWrite !== 1'b1 || WriteRegister !== 5'd9) begin
            fails++;
            $display("FAIL busy9_inflight: got ir=%b RW=%b WR=%0d, want 0/1/9", issue_ready, RegWrite, WriteRegister);
        end
        step();
        checks++;
        if (issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL busy9_retired: got issue_ready=%b, want 1", issue_ready);
        end
        issue_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        issue_valid = 1'b1; issue_rd = 5'd2;
        step();
        issue_valid = 1'b0;
        rs1 = 5'd2; rs2 = 5'd0;
        req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'h22;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || stall !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: got r0=%b st=%b, want 1/1", req0_ready, stall);
        end
        #6;
        rst = 1'b1;  // held across the would-be handshake edge
        step();
        checks++;
        if (RegWrite !== 1'b0 || stall !== 1'b0 || req0_ready !== 1'b0 || issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_during: got RW=%b st=%b r0=%b ir=%b, want 0/0/0/1", RegWrite, stall, req0_ready, issue_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_first_cycle: got r0=%b, want 0", req0_ready);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (RegWrite !== 1'b0 || stall !== 1'b0) begin
                fails++;
                $display("FAIL rst_nowrite%0d: got RW=%b st=%b, want 0/0", i, RegWrite, stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_writeback();
        test_contention();
        test_set_wins();
        test_zero_reg();
        test_issue_block();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
